regfile_multiport_sb: RTL and testbench

//   Parametrised multi-read, single-write register file with write-to-read bypass and a
//   per-register pending scoreboard. It replaces the fixed 32x32 two-read-port file in the

---
 rtl/regfile_multiport_sb_if.sv | 28 ++
 rtl/regfile_multiport_sb.sv | 78 +++++++
 tb/tb_regfile_multiport_sb.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_multiport_sb_if.sv
// Bus bundle for the multi-port register file: write, alloc and read-port signals.
// Handshake: no valid/ready pair; wr_en and alloc_en are single-cycle strobes sampled on the rising clk edge, and reads are combinational with no flow control.
interface regfile_multiport_sb_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2
);
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     alloc_en;
    logic [ADDR_W-1:0]        alloc_addr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_pend;
    logic [NUM_REGS-1:0]      pend_vec;

    modport master (
        output wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
        input  rd_data, rd_pend, pend_vec
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, alloc_en, alloc_addr, rd_addr,
        output rd_data, rd_pend, pend_vec
    );
endinterface

// File: rtl/regfile_multiport_sb.sv
// Multi-read, single-write register file with write-to-read bypass and a per-register
// pending scoreboard (alloc sets, writeback clears, alloc wins on a same-edge collision).
module regfile_multiport_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic                   clk,
    input logic                   reset,
    regfile_multiport_sb_if.slave bus
);
    logic [DATA_W-1:0]              regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]            pend_q;
    logic [NUM_REGS-1:0]            pend_d;
    logic                           wr_ok;
    logic                           alloc_ok;
    logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0]  rd_data;
    logic [NUM_RD-1:0]              rd_pend;

    // In range and not the hardwired zero register.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_ok    = bus.wr_en && writable(bus.wr_addr);
    assign alloc_ok = bus.alloc_en && writable(bus.alloc_addr);

    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[bus.wr_addr] = 1'b0;
        end
        if (alloc_ok) begin
            pend_d[bus.alloc_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_ok) begin
                regs_q[bus.wr_addr] <= bus.wr_data;
            end
            pend_q <= pend_d;
        end
    end

    assign rd_addr = bus.rd_addr;

    // Unreadable indices and the whole reset period read as zero / not pending.
    always_comb begin
        rd_data = '0;
        rd_pend = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            if (!reset && writable(rd_addr[p])) begin
                if ((BYPASS != 0) && bus.wr_en && (bus.wr_addr == rd_addr[p])) begin
                    rd_data[p] = bus.wr_data;
                    rd_pend[p] = bus.alloc_en && (bus.alloc_addr == rd_addr[p]);
                end else begin
                    rd_data[p] = regs_q[rd_addr[p]];
                    rd_pend[p] = pend_q[rd_addr[p]];
                end
            end
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_pend  = rd_pend;
    assign bus.pend_vec = pend_q;
endmodule

// File: tb/tb_regfile_multiport_sb.sv
// Bench for regfile_multiport_sb: instance A uses default parameters; instance B has 24 regs,
// 3 read ports, no zero register and no bypass.
module tb_regfile_multiport_sb;
    localparam int DW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    regfile_multiport_sb_if #(.DATA_W(DW), .NUM_REGS(32), .ADDR_W(AW), .NUM_RD(2)) bus_a ();
    regfile_multiport_sb_if #(.DATA_W(DW), .NUM_REGS(24), .ADDR_W(AW), .NUM_RD(3)) bus_b ();

    regfile_multiport_sb #(.DATA_W(DW), .NUM_REGS(32), .ADDR_W(AW), .NUM_RD(2),
                           .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    regfile_multiport_sb #(.DATA_W(DW), .NUM_REGS(24), .ADDR_W(AW), .NUM_RD(3),
                           .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    int cfg_nregs [2] = '{32, 24};
    int cfg_zero  [2] = '{1, 0};
    int cfg_byp   [2] = '{1, 0};
    int cfg_nrd   [2] = '{2, 3};

    // Reference model: register contents and pending flags per instance.
    logic [DW-1:0] m_regs [2][32];
    bit            m_pend [2][32];

    // Last stimulus driven to each instance.
    bit            st_we [2];
    int            st_wa [2];
    logic [DW-1:0] st_wd [2];
    bit            st_ae [2];
    int            st_aa [2];
    int            st_ra [2][3];

    int n_pass = 0;
    int n_total = 0;

    function automatic bit m_ok(input int i, input int a);
        return (a < cfg_nregs[i]) && !(cfg_zero[i] == 1 && a == 0);
    endfunction

    function automatic logic [DW-1:0] m_rdata(input int i, input int p);
        int a = st_ra[i][p];
        if (reset || !m_ok(i, a)) return '0;
        if (cfg_byp[i] == 1 && st_we[i] && st_wa[i] == a) return st_wd[i];
        return m_regs[i][a];
    endfunction

    function automatic bit m_rpend(input int i, input int p);
        int a = st_ra[i][p];
        if (reset || !m_ok(i, a)) return 1'b0;
        if (cfg_byp[i] == 1 && st_we[i] && st_wa[i] == a) return st_ae[i] && st_aa[i] == a;
        return m_pend[i][a];
    endfunction

    function automatic logic [31:0] m_pvec(input int i);
        logic [31:0] v = '0;
        for (int r = 0; r < cfg_nregs[i]; r++) v[r] = m_pend[i][r];
        return v;
    endfunction

    function automatic logic [DW-1:0] act_rdata(input int i, input int p);
        return (i == 0) ? bus_a.rd_data[p*DW +: DW] : bus_b.rd_data[p*DW +: DW];
    endfunction

    function automatic logic act_rpend(input int i, input int p);
        return (i == 0) ? bus_a.rd_pend[p] : bus_b.rd_pend[p];
    endfunction

    function automatic logic [31:0] act_pvec(input int i);
        return (i == 0) ? bus_a.pend_vec : {8'b0, bus_b.pend_vec};
    endfunction

    task automatic set_in(input int i, input bit we, input int wa, input logic [DW-1:0] wd,
                          input bit ae, input int aa, input int r0, input int r1, input int r2);
        st_we[i] = we; st_wa[i] = wa; st_wd[i] = wd; st_ae[i] = ae; st_aa[i] = aa;
        st_ra[i][0] = r0; st_ra[i][1] = r1; st_ra[i][2] = r2;
        if (i == 0) begin
            bus_a.wr_en = we; bus_a.wr_addr = AW'(wa); bus_a.wr_data = wd;
            bus_a.alloc_en = ae; bus_a.alloc_addr = AW'(aa);
            bus_a.rd_addr = {AW'(r1), AW'(r0)};
        end else begin
            bus_b.wr_en = we; bus_b.wr_addr = AW'(wa); bus_b.wr_data = wd;
            bus_b.alloc_en = ae; bus_b.alloc_addr = AW'(aa);
            bus_b.rd_addr = {AW'(r2), AW'(r1), AW'(r0)};
        end
    endtask

    task automatic idle_both();
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    // One rising edge: the model commits what was driven, then we return at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[i][r] = '0;
                    m_pend[i][r] = 1'b0;
                end
            end else begin
                if (st_we[i] && m_ok(i, st_wa[i])) begin
                    m_regs[i][st_wa[i]] = st_wd[i];
                    m_pend[i][st_wa[i]] = 1'b0;
                end
                if (st_ae[i] && m_ok(i, st_aa[i])) m_pend[i][st_aa[i]] = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_in(0, 1, 9, 32'hAB, 1, 9, 9, 9, 0);
        set_in(1, 1, 9, 32'hAB, 1, 9, 9, 9, 9);
        for (int c = 0; c < 2; c++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < cfg_nrd[i]; p++) begin
                    n_total++;
                    if (act_rdata(i, p) !== '0 || act_rpend(i, p) !== 1'b0)
                        $display("FAIL reset_read inst%0d p%0d: got data=%h pend=%b want 0/0",
                                 i, p, act_rdata(i, p), act_rpend(i, p));
                    else n_pass++;
                end
            end
            step();
        end
        reset = 1'b0;
        idle_both();
        for (int idx = 1; idx < 32; idx++) begin
            set_in(0, 0, 0, '0, 0, 0, idx, idx, idx);
            set_in(1, 0, 0, '0, 0, 0, idx, idx, idx);
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < cfg_nrd[i]; p++) begin
                    n_total++;
                    if (act_rdata(i, p) !== '0 || act_rpend(i, p) !== 1'b0)
                        $display("FAIL post_reset_read inst%0d r%0d p%0d: got %h/%b want 0/0",
                                 i, idx, p, act_rdata(i, p), act_rpend(i, p));
                    else n_pass++;
                end
                n_total++;
                if (act_pvec(i) !== 32'h0)
                    $display("FAIL post_reset_pend_vec inst%0d: got %h want 0", i, act_pvec(i));
                else n_pass++;
            end
            #1;
        end
        @(negedge clk);
    endtask

    task automatic test_bypass_write();
        set_in(0, 1, 1, 32'h21, 0, 0, 1, 1, 0);
        set_in(1, 1, 1, 32'h21, 0, 0, 1, 1, 1);
        #1;
        for (int p = 0; p < 2; p++) begin
            n_total++;
            if (act_rdata(0, p) !== 32'h21 || act_rpend(0, p) !== 1'b0)
                $display("FAIL bypass_same_cycle p%0d: got %h/%b want 00000021/0",
                         p, act_rdata(0, p), act_rpend(0, p));
            else n_pass++;
        end
        n_total++;
        if (act_rdata(1, 0) !== 32'h0)
            $display("FAIL nobypass_same_cycle: got %h want 00000000", act_rdata(1, 0));
        else n_pass++;
        step();
        set_in(0, 0, 0, '0, 0, 0, 1, 0, 0);
        set_in(1, 0, 0, '0, 0, 0, 0, 1, 0);
        #1;
        n_total++;
        if (act_rdata(0, 0) !== 32'h21)
            $display("FAIL bypass_after_edge: got %h want 00000021", act_rdata(0, 0));
        else n_pass++;
        n_total++;
        if (act_rdata(1, 1) !== 32'h21)
            $display("FAIL nobypass_after_edge: got %h want 00000021", act_rdata(1, 1));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_zero_reg();
        set_in(0, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        set_in(1, 1, 0, 32'hDEADBEEF, 1, 0, 0, 0, 0);
        #1;
        n_total++;
        if (act_rdata(0, 0) !== 32'h0 || act_rpend(0, 0) !== 1'b0)
            $display("FAIL zero_reg_bypass: got %h/%b want 0/0", act_rdata(0, 0), act_rpend(0, 0));
        else n_pass++;
        step();
        set_in(0, 0, 0, '0, 0, 0, 0, 0, 0);
        set_in(1, 0, 0, '0, 0, 0, 0, 0, 0);
        #1;
        n_total++;
        if (act_rdata(0, 1) !== 32'h0 || act_pvec(0) !== 32'h0)
            $display("FAIL zero_reg_read: got data=%h pend_vec=%h want 0/0",
                     act_rdata(0, 1), act_pvec(0));
        else n_pass++;
        n_total++;
        if (act_rdata(1, 0) !== 32'hDEADBEEF || act_rpend(1, 0) !== 1'b1 || act_pvec(1) !== 32'h1)
            $display("FAIL plain_reg0: got %h/%b pend_vec=%h want deadbeef/1/00000001",
                     act_rdata(1, 0), act_rpend(1, 0), act_pvec(1));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_alloc_clear();
        set_in(0, 0, 0, '0, 1, 5, 5, 0, 0);
        step();
        set_in(0, 0, 0, '0, 0, 0, 5, 5, 0);
        #1;
        n_total++;
        if (act_rpend(0, 0) !== 1'b1 || act_rpend(0, 1) !== 1'b1 || act_pvec(0) !== 32'h20)
            $display("FAIL alloc_pending: got %b%b pend_vec=%h want 11/00000020",
                     act_rpend(0, 1), act_rpend(0, 0), act_pvec(0));
        else n_pass++;
        set_in(0, 1, 5, 32'h5, 0, 0, 5, 5, 0);
        #1;
        n_total++;
        if (act_rdata(0, 0) !== 32'h5 || act_rpend(0, 0) !== 1'b0)
            $display("FAIL writeback_bypass: got %h/%b want 00000005/0",
                     act_rdata(0, 0), act_rpend(0, 0));
        else n_pass++;
        step();
        set_in(0, 0, 0, '0, 0, 0, 5, 0, 0);
        #1;
        n_total++;
        if (act_pvec(0) !== 32'h0 || act_rdata(0, 0) !== 32'h5 || act_rpend(0, 0) !== 1'b0)
            $display("FAIL writeback_clear: got pend_vec=%h data=%h pend=%b want 0/00000005/0",
                     act_pvec(0), act_rdata(0, 0), act_rpend(0, 0));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_write_alloc();
        set_in(0, 1, 7, 32'h7, 1, 7, 7, 7, 0);
        #1;
        n_total++;
        if (act_rdata(0, 1) !== 32'h7 || act_rpend(0, 1) !== 1'b1)
            $display("FAIL same_reg_bypass: got %h/%b want 00000007/1",
                     act_rdata(0, 1), act_rpend(0, 1));
        else n_pass++;
        step();
        set_in(0, 1, 10, 32'hA0, 1, 11, 7, 10, 0);
        #1;
        n_total++;
        if (act_rdata(0, 0) !== 32'h7 || act_pvec(0) !== 32'h80)
            $display("FAIL same_reg_alloc_wins: got %h pend_vec=%h want 00000007/00000080",
                     act_rdata(0, 0), act_pvec(0));
        else n_pass++;
        step();
        set_in(0, 0, 0, '0, 0, 0, 10, 11, 0);
        #1;
        n_total++;
        if (act_rdata(0, 0) !== 32'hA0 || act_rpend(0, 0) !== 1'b0 || act_rpend(0, 1) !== 1'b1 ||
            act_pvec(0) !== 32'h880)
            $display("FAIL diff_reg_both: got %h pend=%b%b pend_vec=%h want 000000a0/10/00000880",
                     act_rdata(0, 0), act_rpend(0, 1), act_rpend(0, 0), act_pvec(0));
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_out_of_range();
        logic [31:0] pv_before;
        pv_before = m_pvec(1);
        set_in(1, 1, 30, 32'h30, 1, 30, 30, 24, 31);
        #1;
        for (int p = 0; p < 3; p++) begin
            n_total++;
            if (act_rdata(1, p) !== '0 || act_rpend(1, p) !== 1'b0)
                $display("FAIL oor_read_same p%0d: got %h/%b want 0/0",
                         p, act_rdata(1, p), act_rpend(1, p));
            else n_pass++;
        end
        step();
        set_in(1, 1, 23, 32'h23, 1, 23, 30, 23, 0);
        #1;
        n_total++;
        if (act_rdata(1, 0) !== '0 || act_pvec(1) !== pv_before)
            $display("FAIL oor_ignored: got %h pend_vec=%h want 0/%h",
                     act_rdata(1, 0), act_pvec(1), pv_before);
        else n_pass++;
        step();
        set_in(1, 0, 0, '0, 0, 0, 23, 23, 30);
        #1;
        n_total++;
        if (act_rdata(1, 1) !== 32'h23 || act_rpend(1, 1) !== 1'b1 ||
            act_pvec(1) !== (pv_before | 32'h0080_0000))
            $display("FAIL last_reg: got %h/%b pend_vec=%h want 00000023/1/%h",
                     act_rdata(1, 1), act_rpend(1, 1), act_pvec(1), pv_before | 32'h0080_0000);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                set_in(i, $urandom_range(0, 1), $urandom_range(0, 31), $urandom,
                       ($urandom_range(0, 2) == 0), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
                if ($urandom_range(0, 3) == 0) st_ra[i][0] = st_wa[i];
                if (i == 0) bus_a.rd_addr[AW-1:0] = AW'(st_ra[i][0]);
                else bus_b.rd_addr[AW-1:0] = AW'(st_ra[i][0]);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                for (int p = 0; p < cfg_nrd[i]; p++) begin
                    n_total++;
                    if (act_rdata(i, p) !== m_rdata(i, p) || act_rpend(i, p) !== m_rpend(i, p))
                        $display("FAIL rand_read c%0d inst%0d p%0d r%0d: got %h/%b want %h/%b",
                                 c, i, p, st_ra[i][p], act_rdata(i, p), act_rpend(i, p),
                                 m_rdata(i, p), m_rpend(i, p));
                    else n_pass++;
                end
            end
            step();
            for (int i = 0; i < 2; i++) begin
                n_total++;
                if (act_pvec(i) !== m_pvec(i))
                    $display("FAIL rand_pend_vec c%0d inst%0d: got %h want %h",
                             c, i, act_pvec(i), m_pvec(i));
                else n_pass++;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++)
            for (int r = 0; r < 32; r++) begin
                m_regs[i][r] = '0;
                m_pend[i][r] = 1'b0;
            end
        idle_both();
        @(negedge clk);
        test_reset();
        test_bypass_write();
        test_zero_reg();
        test_alloc_clear();
        test_write_alloc();
        test_out_of_range();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
